// File: rtl/plab3_mem_line_word_adapter_pkg.sv
// Shared memory-message widths, type encodings and width helpers used by the
// line-to-word adapter. Field order, MSB first:
//   request  : {type, opaque, addr, len, data}
//   response : {type, opaque, len, data}
package plab3_mem_line_word_adapter_pkg;

    localparam int MEM_TYPE_NBITS = 3;

    localparam logic [MEM_TYPE_NBITS-1:0] MEM_READ  = 3'd0;
    localparam logic [MEM_TYPE_NBITS-1:0] MEM_WRITE = 3'd1;
    localparam logic [MEM_TYPE_NBITS-1:0] MEM_INIT  = 3'd2;

    // Width of the len field for a given data width (bytes per beat, log2)
    function automatic int mem_len_nbits(input int d);
        return $clog2(d / 8);
    endfunction

    function automatic int mem_req_nbits(input int o, input int a, input int d);
        return MEM_TYPE_NBITS + o + a + mem_len_nbits(d) + d;
    endfunction

    function automatic int mem_resp_nbits(input int o, input int d);
        return MEM_TYPE_NBITS + o + mem_len_nbits(d) + d;
    endfunction

endpackage

// File: rtl/plab3_mem_line_word_adapter_line_buf.sv
// Cacheline buffer: one word slot per downstream beat. A full line can be
// loaded in parallel, single slots can be overwritten by index, and the whole
// line is always visible on the read port.
module plab3_mem_line_buf
    import plab3_mem_line_word_adapter_pkg::*;
#(
    parameter int dbw    = 32,
    parameter int nwords = 4
)(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load_en,
    input  logic [nwords*dbw-1:0]      load_line,
    input  logic                       wr_en,
    input  logic [$clog2(nwords)-1:0]  wr_idx,
    input  logic [dbw-1:0]             wr_data,
    output logic [nwords*dbw-1:0]      line
);

    logic [nwords*dbw-1:0] line_q;

    // Parallel load has priority over the single-slot write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line_q <= '0;
        end else if (load_en) begin
            line_q <= load_line;
        end else if (wr_en) begin
            line_q[wr_idx*dbw +: dbw] <= wr_data;
        end
    end

    assign line = line_q;

endmodule

// File: rtl/plab3_mem_line_word_adapter.sv
// Splits one cacheline request into four sequential word requests and gathers
// the word responses back into one line response. Only one word request is
// ever outstanding; word responses are assumed to return in order.
module plab3_mem_line_word_adapter
    import plab3_mem_line_word_adapter_pkg::*;
#(
    parameter int p_opaque_nbits = 8,
    parameter int abw            = 32,
    parameter int clw            = 128,
    parameter int dbw            = 32
)(
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          domain,

    input  logic                                          linereq_val,
    output logic                                          linereq_rdy,
    input  logic [mem_req_nbits(p_opaque_nbits,abw,clw)-1:0] linereq_msg,

    output logic                                          lineresp_val,
    input  logic                                          lineresp_rdy,
    output logic [mem_resp_nbits(p_opaque_nbits,clw)-1:0] lineresp_msg,

    output logic                                          wordreq_val,
    input  logic                                          wordreq_rdy,
    output logic [mem_req_nbits(p_opaque_nbits,abw,dbw)-1:0] wordreq_msg,

    input  logic                                          wordresp_val,
    output logic                                          wordresp_rdy,
    input  logic [mem_resp_nbits(p_opaque_nbits,dbw)-1:0] wordresp_msg,

    output logic                                          txn_domain
);

    localparam int LREQ_W  = mem_req_nbits(p_opaque_nbits, abw, clw);
    localparam int WRESP_W = mem_resp_nbits(p_opaque_nbits, dbw);
    localparam int CL_LEN  = mem_len_nbits(clw);
    localparam int W_LEN   = mem_len_nbits(dbw);
    localparam int NWORDS  = clw / dbw;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t state, state_next;

    logic [1:0]                k;
    logic [2:0]                type_q;
    logic [p_opaque_nbits-1:0] opaque_q;
    logic [abw-1:0]            addr_q;
    logic                      domain_q;
    logic [clw-1:0]            line_q;

    // Line request field extraction
    logic [2:0]                lr_type;
    logic [p_opaque_nbits-1:0] lr_opaque;
    logic [abw-5:0]            lr_addr_hi;
    logic [clw-1:0]            lr_data;

    assign lr_type    = linereq_msg[LREQ_W-1 -: 3];
    assign lr_opaque  = linereq_msg[LREQ_W-4 -: p_opaque_nbits];
    assign lr_addr_hi = linereq_msg[clw+CL_LEN+4 +: abw-4];
    assign lr_data    = linereq_msg[clw-1:0];

    logic line_accept, word_done, resp_done;
    assign line_accept = (state == ST_IDLE) && linereq_val;
    assign word_done   = (state == ST_WAIT) && wordresp_val;
    assign resp_done   = (state == ST_RESP) && lineresp_rdy;

    // Line length, request address low bits and word-response header are
    // deliberately ignored by this block
    logic unused_msg_bits;
    assign unused_msg_bits = &{1'b0, linereq_msg[clw +: CL_LEN+4],
                               wordresp_msg[WRESP_W-1:dbw]};

    plab3_mem_line_buf #(
        .dbw    (dbw),
        .nwords (NWORDS)
    ) line_buf (
        .clk       (clk),
        .reset     (reset),
        .load_en   (line_accept),
        .load_line (lr_data),
        .wr_en     (word_done),
        .wr_idx    (k),
        .wr_data   (wordresp_msg[dbw-1:0]),
        .line      (line_q)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Transaction header and word index; k only wraps on line completion
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k        <= 2'd0;
            type_q   <= '0;
            opaque_q <= '0;
            addr_q   <= '0;
            domain_q <= 1'b0;
        end else if (line_accept) begin
            k        <= 2'd0;
            type_q   <= lr_type;
            opaque_q <= lr_opaque;
            addr_q   <= {lr_addr_hi, 4'h0};
            domain_q <= domain;
        end else if (word_done && (k != 2'd3)) begin
            k <= k + 2'd1;
        end else if (resp_done) begin
            k <= 2'd0;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next   = state;
        linereq_rdy  = 1'b0;
        wordreq_val  = 1'b0;
        wordresp_rdy = 1'b0;
        lineresp_val = 1'b0;
        case (state)
            ST_IDLE: begin
                linereq_rdy = 1'b1;
                if (linereq_val) state_next = ST_REQ;
            end
            ST_REQ: begin
                wordreq_val = 1'b1;
                if (wordreq_rdy) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                wordresp_rdy = 1'b1;
                if (wordresp_val) state_next = (k == 2'd3) ? ST_RESP : ST_REQ;
            end
            ST_RESP: begin
                lineresp_val = 1'b1;
                if (lineresp_rdy) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign wordreq_msg = {type_q,
                          {{(p_opaque_nbits-2){1'b0}}, k},
                          addr_q + {{(abw-4){1'b0}}, k, 2'b00},
                          {W_LEN{1'b0}},
                          line_q[dbw*k +: dbw]};

    assign lineresp_msg = {type_q,
                           opaque_q,
                           {CL_LEN{1'b0}},
                           (type_q == MEM_READ) ? line_q : {clw{1'b0}}};

    assign txn_domain = domain_q;

endmodule

// File: tb/tb_plab3_mem_line_word_adapter.sv
// Directed bench for the line-to-word adapter: a small memory responder is
// driven from the stimulus task and every observed field is compared with
// values derived from the stimulus itself.
module tb_plab3_mem_line_word_adapter;
    import plab3_mem_line_word_adapter_pkg::*;

    localparam int O  = 8;
    localparam int A  = 32;
    localparam int CL = 128;
    localparam int DW = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         domain = 1'b0;
    logic         linereq_val = 1'b0;
    logic         linereq_rdy;
    logic [174:0] linereq_msg = '0;
    logic         lineresp_val;
    logic         lineresp_rdy = 1'b0;
    logic [142:0] lineresp_msg;
    logic         wordreq_val;
    logic         wordreq_rdy = 1'b0;
    logic [76:0]  wordreq_msg;
    logic         wordresp_val = 1'b0;
    logic         wordresp_rdy;
    logic [44:0]  wordresp_msg = '0;
    logic         txn_domain;

    int n_checks = 0;
    int n_errors = 0;
    int lat = 0;
    int n_wreq = 0;

    plab3_mem_line_word_adapter #(
        .p_opaque_nbits (O),
        .abw            (A),
        .clw            (CL),
        .dbw            (DW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .domain       (domain),
        .linereq_val  (linereq_val),
        .linereq_rdy  (linereq_rdy),
        .linereq_msg  (linereq_msg),
        .lineresp_val (lineresp_val),
        .lineresp_rdy (lineresp_rdy),
        .lineresp_msg (lineresp_msg),
        .wordreq_val  (wordreq_val),
        .wordreq_rdy  (wordreq_rdy),
        .wordreq_msg  (wordreq_msg),
        .wordresp_val (wordresp_val),
        .wordresp_rdy (wordresp_rdy),
        .wordresp_msg (wordresp_msg),
        .txn_domain   (txn_domain)
    );

    always #5 clk = ~clk;

    // Count issued word requests to detect duplicates
    always @(posedge clk) begin
        if (reset && wordreq_val && wordreq_rdy) n_wreq <= n_wreq + 1;
    end

    task automatic check_val(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        lat++;
    endtask

    // One full line transaction; starts and ends on a negedge with the DUT idle
    task automatic do_line(input string name, input logic [2:0] typ, input logic [7:0] opq,
                           input logic [31:0] addr, input logic [127:0] ldata,
                           input logic [127:0] mwords, input logic dom,
                           input int stall_word, input int stall_cycles, input int resp_stall,
                           input bit junk, input bit chk_lat);
        logic [31:0]  base;
        logic [76:0]  snap;
        logic [142:0] rsnap;
        logic [127:0] exp_data;
        int           to;
        int           n0;
        base = {addr[31:4], 4'h0};
        exp_data = (typ == MEM_READ) ? mwords : 128'h0;
        n0 = n_wreq;

        domain = dom;
        linereq_msg = {typ, opq, addr, 4'h0, ldata};
        linereq_val = 1'b1;
        check_val({name, ".lreq_rdy"}, 160'(linereq_rdy), 160'(1));
        @(posedge clk);
        @(negedge clk);
        lat = 0;
        linereq_val = 1'b0;
        linereq_msg = '0;
        domain = ~dom;
        check_val({name, ".domain_hold"}, 160'(txn_domain), 160'(dom));

        for (int k = 0; k < 4; k++) begin
            if (junk) begin
                wordresp_val = 1'b1;
                wordresp_msg = {3'd0, 8'hEE, 2'b00, 32'hBAD0BAD0};
            end
            to = 0;
            while (!wordreq_val && to < 20) begin
                step();
                to++;
            end
            if (!wordreq_val) begin
                check_val($sformatf("%s.wreq_timeout%0d", name, k), 160'(0), 160'(1));
                wordresp_val = 1'b0;
                return;
            end
            if (junk) check_val($sformatf("%s.wresp_rdy_in_req%0d", name, k), 160'(wordresp_rdy), 160'(0));
            check_val($sformatf("%s.wtype%0d", name, k), 160'(wordreq_msg[76:74]), 160'(typ));
            check_val($sformatf("%s.wopq%0d", name, k), 160'(wordreq_msg[73:66]), 160'(k));
            check_val($sformatf("%s.waddr%0d", name, k), 160'(wordreq_msg[65:34]), 160'(base + 32'(4*k)));
            check_val($sformatf("%s.wlen%0d", name, k), 160'(wordreq_msg[33:32]), 160'(0));
            check_val($sformatf("%s.wdata%0d", name, k), 160'(wordreq_msg[31:0]), 160'(ldata[32*k +: 32]));
            snap = wordreq_msg;
            if (k == stall_word) begin
                for (int s = 0; s < stall_cycles; s++) begin
                    step();
                    check_val($sformatf("%s.wreq_hold_val%0d", name, s), 160'(wordreq_val), 160'(1));
                    check_val($sformatf("%s.wreq_stable%0d", name, s), 160'(wordreq_msg), 160'(snap));
                end
            end
            wordreq_rdy = 1'b1;
            step();
            wordreq_rdy = 1'b0;
            check_val($sformatf("%s.wait_wreq_val%0d", name, k), 160'(wordreq_val), 160'(0));
            check_val($sformatf("%s.wait_wresp_rdy%0d", name, k), 160'(wordresp_rdy), 160'(1));
            wordresp_val = 1'b1;
            wordresp_msg = {typ, 8'h00, 2'b00, mwords[32*k +: 32]};
            step();
            wordresp_val = 1'b0;
            wordresp_msg = '0;
        end

        check_val({name, ".lresp_val"}, 160'(lineresp_val), 160'(1));
        if (chk_lat) check_val({name, ".latency"}, 160'(lat), 160'(8));
        check_val({name, ".lresp_type"}, 160'(lineresp_msg[142:140]), 160'(typ));
        check_val({name, ".lresp_opq"}, 160'(lineresp_msg[139:132]), 160'(opq));
        check_val({name, ".lresp_len"}, 160'(lineresp_msg[131:128]), 160'(0));
        check_val({name, ".lresp_data"}, 160'(lineresp_msg[127:0]), 160'(exp_data));
        check_val({name, ".lreq_rdy_busy"}, 160'(linereq_rdy), 160'(0));
        check_val({name, ".domain_end"}, 160'(txn_domain), 160'(dom));
        rsnap = lineresp_msg;
        for (int s = 0; s < resp_stall; s++) begin
            step();
            check_val($sformatf("%s.lresp_stable%0d", name, s), 160'(lineresp_msg), 160'(rsnap));
            check_val($sformatf("%s.lreq_rdy_stall%0d", name, s), 160'(linereq_rdy), 160'(0));
        end
        lineresp_rdy = 1'b1;
        step();
        lineresp_rdy = 1'b0;
        check_val({name, ".lresp_val_done"}, 160'(lineresp_val), 160'(0));
        check_val({name, ".lreq_rdy_idle"}, 160'(linereq_rdy), 160'(1));
        check_val({name, ".word_issues"}, 160'(n_wreq - n0), 160'(4));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst.wreq_val", 160'(wordreq_val), 160'(0));
        check_val("rst.lresp_val", 160'(lineresp_val), 160'(0));
        check_val("rst.wresp_rdy", 160'(wordresp_rdy), 160'(0));
        check_val("rst.txn_domain", 160'(txn_domain), 160'(0));
        reset = 1'b1;
        @(negedge clk);
        check_val("rst.lreq_rdy", 160'(linereq_rdy), 160'(1));

        // Read line, best-case latency, stray word responses during REQ
        do_line("rd1", MEM_READ, 8'h5A, 32'h00001230, 128'h0,
                {32'h44, 32'h33, 32'h22, 32'h11}, 1'b1, -1, 0, 0, 1'b1, 1'b1);

        // Write line with unaligned address
        do_line("wr1", MEM_WRITE, 8'h3C, 32'h0000200C,
                {32'hDDDD, 32'hCCCC, 32'hBBBB, 32'hAAAA}, 128'h0, 1'b0, -1, 0, 0, 1'b0, 1'b1);

        // Back-pressure on word 2 and on the line response
        do_line("rd2", MEM_READ, 8'hA7, 32'h00004000, {4{32'hFFFF_FFFF}},
                {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000}, 1'b1, 2, 3, 5, 1'b0, 1'b0);

        // Non read/write type forwarded unchanged, response data zero
        do_line("init", MEM_INIT, 8'h01, 32'h00005008,
                {32'h4, 32'h3, 32'h2, 32'h1}, {32'h9, 32'h8, 32'h7, 32'h6}, 1'b0, -1, 0, 0, 1'b0, 1'b1);

        // Reset while waiting for the response to word 1
        domain = 1'b1;
        linereq_msg = {MEM_READ, 8'h77, 32'h00003000, 4'h0, 128'h0};
        linereq_val = 1'b1;
        @(posedge clk);
        @(negedge clk);
        linereq_val = 1'b0;
        wordreq_rdy = 1'b1;
        @(negedge clk);
        wordreq_rdy = 1'b0;
        wordresp_val = 1'b1;
        wordresp_msg = {3'd0, 8'h0, 2'b0, 32'hDEAD0000};
        @(negedge clk);
        wordresp_val = 1'b0;
        check_val("mid.wreq_addr_k1", 160'(wordreq_msg[65:34]), 160'(32'h00003004));
        wordreq_rdy = 1'b1;
        @(negedge clk);
        wordreq_rdy = 1'b0;
        check_val("mid.wresp_rdy", 160'(wordresp_rdy), 160'(1));
        check_val("mid.txn_domain", 160'(txn_domain), 160'(1));
        #2 reset = 1'b0;
        #1;
        check_val("mid.rst_wreq_val", 160'(wordreq_val), 160'(0));
        check_val("mid.rst_lresp_val", 160'(lineresp_val), 160'(0));
        check_val("mid.rst_wresp_rdy", 160'(wordresp_rdy), 160'(0));
        check_val("mid.rst_domain", 160'(txn_domain), 160'(0));
        @(negedge clk);
        reset = 1'b1;
        do_line("fresh", MEM_READ, 8'h12, 32'h00003000, 128'h0,
                {32'hA4, 32'hA3, 32'hA2, 32'hA1}, 1'b0, -1, 0, 0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
